// File: rtl/cv32e40x_xif_offload_ctrl_pkg.sv
// Shared types for the XIF offload controller.
// FSM state encoding and scoreboard entry layout.
package cv32e40x_xif_offload_ctrl_pkg;

  localparam int unsigned XIF_ID_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_COMMIT,
    COMMIT
  } xif_off_state_e;

  typedef struct packed {
    logic                    valid;
    logic [XIF_ID_MAX_W-1:0] id;
    logic [4:0]              rd;
    logic                    committed;
  } xif_sb_entry_t;

endpackage

// File: rtl/cv32e40x_xif_offload_ctrl_if.sv
// eXtension interface bundle: issue, commit and result channels.
// cpu_* modports face the core, cop_* face the coprocessor.
interface if_xif #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32,
  parameter int unsigned X_RFW_WIDTH = 32
);
  logic                        issue_valid;
  logic                        issue_ready;
  logic [31:0]                 issue_instr;
  logic [2:0][X_RFR_WIDTH-1:0] issue_rs;
  logic [2:0]                  issue_rs_valid;
  logic [X_ID_WIDTH-1:0]       issue_id;
  logic                        issue_accept;
  logic                        issue_writeback;

  logic                        commit_valid;
  logic [X_ID_WIDTH-1:0]       commit_id;
  logic                        commit_kill;

  logic                        result_valid;
  logic                        result_ready;
  logic [X_ID_WIDTH-1:0]       result_id;
  logic [X_RFW_WIDTH-1:0]      result_data;
  logic [4:0]                  result_rd;
  logic                        result_we;
  logic                        result_exc;
  logic [5:0]                  result_exccode;

  modport cpu_issue (
    output issue_valid, issue_instr, issue_rs,
    output issue_rs_valid, issue_id,
    input  issue_ready, issue_accept, issue_writeback
  );
  modport cpu_commit (
    output commit_valid, commit_id, commit_kill
  );
  modport cpu_result (
    input  result_valid, result_id, result_data,
    input  result_rd, result_we, result_exc,
    input  result_exccode,
    output result_ready
  );

  modport cop_issue (
    input  issue_valid, issue_instr, issue_rs,
    input  issue_rs_valid, issue_id,
    output issue_ready, issue_accept, issue_writeback
  );
  modport cop_commit (
    input  commit_valid, commit_id, commit_kill
  );
  modport cop_result (
    output result_valid, result_id, result_data,
    output result_rd, result_we, result_exc,
    output result_exccode,
    input  result_ready
  );
endinterface

// File: rtl/cv32e40x_xif_offload_sb.sv
// Outstanding-instruction scoreboard for XIF offload.
// Commit/kill target the single uncommitted entry; results free committed ones.
module cv32e40x_xif_offload_sb
  import cv32e40x_xif_offload_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [ID_W-1:0]  alloc_id,
  input  logic [4:0]       alloc_rd,
  input  logic             commit_en,
  input  logic             kill_en,
  input  logic [ID_W-1:0]  commit_id,
  input  logic [ID_W-1:0]  lookup_id,
  output logic             lookup_done,
  input  logic             free_en,
  output logic [CNT_W-1:0] count
);
  xif_sb_entry_t           sb_q [DEPTH];
  logic [DEPTH-1:0]        pend_hit;
  logic [DEPTH-1:0]        done_hit;
  logic [DEPTH-1:0]        alloc_sel;
  logic [DEPTH-1:0]        done_sel;
  logic [XIF_ID_MAX_W-1:0] cid;
  logic [XIF_ID_MAX_W-1:0] lid;

  assign cid = XIF_ID_MAX_W'(commit_id);
  assign lid = XIF_ID_MAX_W'(lookup_id);

  // Match decode, first-free / first-hit selection and occupancy.
  always_comb begin
    logic af;
    logic df;
    pend_hit  = '0;
    done_hit  = '0;
    alloc_sel = '0;
    done_sel  = '0;
    count     = '0;
    af        = 1'b0;
    df        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_hit[i] = sb_q[i].valid && !sb_q[i].committed
                    && (sb_q[i].id == cid);
      done_hit[i] = sb_q[i].valid && sb_q[i].committed
                    && (sb_q[i].id == lid);
      if (!sb_q[i].valid && !af) begin
        alloc_sel[i] = 1'b1;
        af           = 1'b1;
      end
      if (done_hit[i] && !df) begin
        done_sel[i] = 1'b1;
        df          = 1'b1;
      end
      count = count + CNT_W'(sb_q[i].valid);
    end
  end

  assign lookup_done = |done_hit;

  // Entry updates: alloc, commit mark, kill free and result free.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_en && alloc_sel[i]) begin
          sb_q[i].valid     <= 1'b1;
          sb_q[i].id        <= XIF_ID_MAX_W'(alloc_id);
          sb_q[i].rd        <= alloc_rd;
          sb_q[i].committed <= 1'b0;
        end else begin
          if (commit_en && pend_hit[i])
            sb_q[i].committed <= 1'b1;
          if ((kill_en && pend_hit[i]) || (free_en && done_sel[i]))
            sb_q[i].valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/cv32e40x_xif_offload_ctrl.sv
// CPU-side XIF initiator: issue/commit FSM plus result writeback.
// Scoreboard tracks accepted instructions until their result returns.
module cv32e40x_xif_offload_ctrl
  import cv32e40x_xif_offload_ctrl_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned X_RFR_WIDTH     = 32,
  parameter int unsigned X_RFW_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   off_valid_i,
  input  logic [31:0]            off_instr_i,
  input  logic [X_RFR_WIDTH-1:0] off_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] off_rs2_i,
  output logic                   off_ready_o,
  output logic                   off_accepted_o,
  output logic                   off_rejected_o,
  input  logic                   commit_i,
  input  logic                   kill_i,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFW_WIDTH-1:0] wb_data_o,
  input  logic                   wb_ready_i,
  output logic                   exc_o,
  output logic [5:0]             exccode_o,
  output logic                   err_o,
  if_xif.cpu_issue               xif_issue,
  if_xif.cpu_commit              xif_commit,
  if_xif.cpu_result              xif_result
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (MAX_OUTSTANDING > (1 << X_ID_WIDTH)) begin : g_bad_depth
    $error("MAX_OUTSTANDING exceeds the XIF ID space");
  end
  if (X_ID_WIDTH > XIF_ID_MAX_W) begin : g_bad_id
    $error("X_ID_WIDTH exceeds scoreboard ID field");
  end

  xif_off_state_e         state_q;
  logic [X_ID_WIDTH-1:0]  id_cnt_q;
  logic [X_ID_WIDTH-1:0]  cur_id_q;
  logic [31:0]            instr_q;
  logic [X_RFR_WIDTH-1:0] rs1_q;
  logic [X_RFR_WIDTH-1:0] rs2_q;
  logic                   issue_valid_q;
  logic                   commit_valid_q;
  logic                   kill_q;
  logic [CNT_W-1:0]       sb_count;
  logic                   issue_hs;
  logic                   res_hs;
  logic                   res_done;

  assign issue_hs = issue_valid_q && xif_issue.issue_ready;
  assign res_hs   = xif_result.result_valid && xif_result.result_ready;

  assign off_ready_o = (state_q == IDLE)
                       && (sb_count < CNT_W'(MAX_OUTSTANDING));

  assign xif_issue.issue_valid    = issue_valid_q;
  assign xif_issue.issue_instr    = instr_q;
  assign xif_issue.issue_rs       = {X_RFR_WIDTH'(0), rs2_q, rs1_q};
  assign xif_issue.issue_rs_valid = 3'b011;
  assign xif_issue.issue_id       = id_cnt_q;

  assign xif_commit.commit_valid = commit_valid_q;
  assign xif_commit.commit_id    = cur_id_q;
  assign xif_commit.commit_kill  = kill_q;

  assign xif_result.result_ready = !wb_valid_o || wb_ready_i;

  cv32e40x_xif_offload_sb #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (X_ID_WIDTH),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk         (clk_i),
    .rst         (rst_i),
    .alloc_en    (issue_hs && xif_issue.issue_accept
                  && xif_issue.issue_writeback),
    .alloc_id    (id_cnt_q),
    .alloc_rd    (instr_q[11:7]),
    .commit_en   (commit_valid_q && !kill_q),
    .kill_en     (commit_valid_q && kill_q),
    .commit_id   (cur_id_q),
    .lookup_id   (xif_result.result_id),
    .lookup_done (res_done),
    .free_en     (res_hs && res_done),
    .count       (sb_count)
  );

  // Offload FSM: capture, issue handshake, wait for and send commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      id_cnt_q       <= '0;
      cur_id_q       <= '0;
      instr_q        <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      issue_valid_q  <= 1'b0;
      commit_valid_q <= 1'b0;
      kill_q         <= 1'b0;
      off_accepted_o <= 1'b0;
      off_rejected_o <= 1'b0;
    end else begin
      off_accepted_o <= 1'b0;
      off_rejected_o <= 1'b0;
      commit_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (off_valid_i && off_ready_o) begin
            instr_q       <= off_instr_i;
            rs1_q         <= off_rs1_i;
            rs2_q         <= off_rs2_i;
            issue_valid_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (xif_issue.issue_ready) begin
            issue_valid_q <= 1'b0;
            cur_id_q      <= id_cnt_q;
            id_cnt_q      <= id_cnt_q + X_ID_WIDTH'(1);
            if (xif_issue.issue_accept) begin
              off_accepted_o <= 1'b1;
              state_q        <= WAIT_COMMIT;
            end else begin
              off_rejected_o <= 1'b1;
              state_q        <= IDLE;
            end
          end
        end
        WAIT_COMMIT: begin
          if (commit_i || kill_i) begin
            kill_q         <= kill_i;
            commit_valid_q <= 1'b1;
            state_q        <= COMMIT;
          end
        end
        COMMIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result handling: writeback register with hold, exc and err pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      exc_o      <= 1'b0;
      exccode_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      exc_o     <= 1'b0;
      exccode_o <= '0;
      err_o     <= 1'b0;
      if (wb_ready_i) wb_valid_o <= 1'b0;
      if (res_hs) begin
        if (!res_done) begin
          err_o <= 1'b1;
        end else if (xif_result.result_exc) begin
          exc_o     <= 1'b1;
          exccode_o <= xif_result.result_exccode;
        end else if (xif_result.result_we) begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= xif_result.result_rd;
          wb_data_o  <= xif_result.result_data;
        end
      end
    end
  end
endmodule
